// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared encodings and defaults for the msrv32 PC stage
package msrv32_pkg;

    localparam int          DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h0000_0000;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_BOOT  = 2'd1,
        S_RUN   = 2'd2
    } pc_state_e;

endpackage

// File: rtl/msrv32_next_pc_mux.sv
// msrv32_next_pc_mux: next-PC selection, redirect and misaligned-target detection
module msrv32_next_pc_mux #(
    parameter int              XLEN         = msrv32_pkg::DEFAULT_XLEN,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = XLEN'(msrv32_pkg::DEFAULT_BOOT_ADDRESS)
) (
    input  logic            i_run,
    input  logic [1:0]      i_pc_src,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_iaddr,
    input  logic [XLEN-1:0] i_epc,
    input  logic [XLEN-1:0] i_trap_address,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_pc_plus_4,
    output logic            o_misaligned,
    output logic            o_redirect
);
    import msrv32_pkg::*;

    logic [XLEN-1:0] w_target;
    logic            w_taken;
    logic            w_jump;

    assign o_pc_plus_4  = i_pc + XLEN'(4);
    assign w_target     = {i_iaddr[XLEN-1:1], 1'b0};
    assign w_taken      = (i_pc_src == PC_SRC_NEXT) && i_branch_taken;
    assign w_jump       = w_taken && !i_iaddr[1];
    assign o_misaligned = i_run && w_taken && i_iaddr[1];
    assign o_redirect   = i_run && ((i_pc_src == PC_SRC_EPC) || (i_pc_src == PC_SRC_TRAP) || w_jump);

    // Before the core is running only the boot vector may be fetched; a
    // misaligned target falls through to the sequential address.
    always_comb begin
        o_next_pc = !i_run                      ? BOOT_ADDRESS   :
                    (i_pc_src == PC_SRC_EPC)    ? i_epc          :
                    (i_pc_src == PC_SRC_TRAP)   ? i_trap_address :
                    (i_pc_src == PC_SRC_NEXT)   ? (w_jump ? w_target : o_pc_plus_4) :
                                                  BOOT_ADDRESS;
    end

endmodule

// File: rtl/msrv32_pc_gen.sv
// msrv32_pc_gen: program counter, boot sequencing, fetch stall and flush generation
module msrv32_pc_gen #(
    parameter logic [31:0] BOOT_ADDRESS = msrv32_pkg::DEFAULT_BOOT_ADDRESS,
    parameter int          XLEN         = msrv32_pkg::DEFAULT_XLEN
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [1:0]      pc_src_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] iaddr_in,
    input  logic [XLEN-1:0] epc_in,
    input  logic [XLEN-1:0] trap_address_in,
    input  logic            ahb_ready_in,
    output logic [XLEN-1:0] i_addr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic            pc_valid_out,
    output logic            flush_out,
    output logic            misaligned_instr_out
);
    import msrv32_pkg::*;

    pc_state_e       r_state;
    pc_state_e       w_state_next;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_flush;
    logic [XLEN-1:0] w_next_pc;
    logic            w_run;
    logic            w_accept;
    logic            w_redirect;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = ahb_ready_in && (r_state != S_RESET);

    msrv32_next_pc_mux #(
        .XLEN         (XLEN),
        .BOOT_ADDRESS (XLEN'(BOOT_ADDRESS))
    ) u_next_pc_mux (
        .i_run          (w_run),
        .i_pc_src       (pc_src_in),
        .i_branch_taken (branch_taken_in),
        .i_iaddr        (iaddr_in),
        .i_epc          (epc_in),
        .i_trap_address (trap_address_in),
        .i_pc           (r_pc),
        .o_next_pc      (w_next_pc),
        .o_pc_plus_4    (pc_plus_4_out),
        .o_misaligned   (misaligned_instr_out),
        .o_redirect     (w_redirect)
    );

    // Boot sequencing state register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) r_state <= S_RESET;
        else           r_state <= w_state_next;
    end

    // Reset -> boot on release, boot -> run once the boot fetch is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RESET: w_state_next = S_BOOT;
            S_BOOT:  w_state_next = ahb_ready_in ? S_RUN : S_BOOT;
            default: w_state_next = S_RUN;
        endcase
    end

    // Advance the PC on an accepted fetch; flush follows an accepted redirect.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_pc       <= XLEN'(BOOT_ADDRESS);
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_flush <= w_accept && w_redirect;
            if (w_accept) begin
                r_pc       <= w_next_pc;
                r_pc_valid <= 1'b1;
            end
        end
    end

    assign i_addr_out   = w_next_pc;
    assign pc_out       = r_pc;
    assign pc_valid_out = r_pc_valid;
    assign flush_out    = r_flush;

endmodule
